// File: rtl/uart_periph_pkg.sv
// Shared constants for the UART peripheral: FSM encodings, status bit indices, bus addresses.
// UART_PARITY_EN adds the PARITY state encoding (8E1 frames).
package uart_periph_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int CON_W        = 5;
  localparam int CON_RX_VALID = 0;
  localparam int CON_TX_BUSY  = 1;
  localparam int CON_TX_DONE  = 2;
  localparam int CON_RX_OVR   = 3;
  localparam int CON_RX_FERR  = 4;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  // Bit period in clocks, floored at 4 so the half-bit start check stays meaningful.
  function automatic int calc_cpb(input int clk_freq, input int baud);
    return ((clk_freq / baud) < 4) ? 4 : (clk_freq / baud);
  endfunction

endpackage

// File: rtl/uart_periph_if.sv
// CPU-side register bus of the UART: TXD write strobe, RXD/CON read strobes and read data.
interface uart_periph_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       rx_read;
  logic       con_read;
  logic [7:0] rx_data;
  logic [4:0] uart_con;

  modport master (output tx_data, tx_start, rx_read, con_read,
                  input  rx_data, uart_con);
  modport slave  (input  tx_data, tx_start, rx_read, con_read,
                  output rx_data, uart_con);
endinterface

// File: rtl/uart_periph_rx_core.sv
// UART receiver: 2-FF synchronizer, RX FSM and mid-bit sampling counter.
// Emits one-cycle good/frame-error pulses; holds the RXD register. UART_PARITY_EN adds a parity check.
module uart_rx_core
  import uart_periph_pkg::*;
#(
  parameter int CPB = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_good,
  output logic       o_rx_ferr
);

  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  logic            r_sync1, r_sync2;
  uart_state_t     r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_stop_ok;

`ifdef UART_PARITY_EN
  logic            r_par_err;
  assign w_stop_ok = r_sync2 && !r_par_err;
`else
  assign w_stop_ok = r_sync2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      o_rx_data <= '0;
      o_rx_good <= 1'b0;
      o_rx_ferr <= 1'b0;
`ifdef UART_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      o_rx_good <= 1'b0;
      o_rx_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!r_sync2) r_state <= ST_START;
        end
        // Half-bit recheck rejects short glitches without flagging anything.
        ST_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_state <= r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
`ifdef UART_PARITY_EN
            if (r_bit == 3'd7) r_state <= ST_PARITY;
`else
            if (r_bit == 3'd7) r_state <= ST_STOP;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == LAST) begin
            r_cnt     <= '0;
            r_par_err <= (r_sync2 != ^r_shift);
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        // Leave right after the mid-bit stop sample so the next start edge is caught early.
        ST_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (w_stop_ok) begin
              o_rx_data <= r_shift;
              o_rx_good <= 1'b1;
            end else begin
              o_rx_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_periph.sv
// UART peripheral top: TX FSM, CON status register, and the uart_rx_core receiver.
// Frame is 8N1 by default; defining UART_PARITY_EN makes it 8E1.
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rx,
  output logic          uart_tx,
  uart_periph_if.slave  bus
);

  localparam int CPB = calc_cpb(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  uart_state_t      r_tx_state;
  logic [CW-1:0]    r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx_par;
  logic             r_tx;
  logic             r_tx_busy;
  logic             r_rx_valid, r_tx_done, r_rx_ovr, r_rx_ferr;
  logic             w_tx_end;
  logic             w_rx_good, w_rx_ferr;
  logic [7:0]       w_rx_data;
  logic [CON_W-1:0] w_con;

  assign w_tx_end = (r_tx_state == ST_STOP) && (r_tx_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      case (r_tx_state)
        // A strobe outside IDLE never reaches here, so bytes written while busy are dropped.
        ST_IDLE: begin
          if (bus.tx_start) begin
            r_tx_shift <= bus.tx_data;
            r_tx_par   <= ^bus.tx_data;
            r_tx_busy  <= 1'b1;
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= ST_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= r_tx_bit + 1'b1;
            r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_tx       <= r_tx_par;
              r_tx_state <= ST_PARITY;
`else
              r_tx       <= 1'b1;
              r_tx_state <= ST_STOP;
`endif
            end else begin
              r_tx <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt   <= '0;
            r_tx       <= 1'b1;
            r_tx_state <= ST_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_tx_end) begin
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_state <= ST_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  // Status flags: a set event beats a same-cycle read clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      if (w_rx_good)                   r_rx_valid <= 1'b1;
      else if (bus.rx_read)            r_rx_valid <= 1'b0;
      if (w_rx_good && r_rx_valid)     r_rx_ovr   <= 1'b1;
      else if (bus.con_read)           r_rx_ovr   <= 1'b0;
      if (w_rx_ferr)                   r_rx_ferr  <= 1'b1;
      else if (bus.con_read)           r_rx_ferr  <= 1'b0;
      if (w_tx_end)                    r_tx_done  <= 1'b1;
      else if (bus.con_read)           r_tx_done  <= 1'b0;
    end
  end

  always_comb begin
    w_con               = '0;
    w_con[CON_RX_VALID] = r_rx_valid;
    w_con[CON_TX_BUSY]  = r_tx_busy;
    w_con[CON_TX_DONE]  = r_tx_done;
    w_con[CON_RX_OVR]   = r_rx_ovr;
    w_con[CON_RX_FERR]  = r_rx_ferr;
  end

  assign uart_tx      = r_tx;
  assign bus.uart_con = w_con;
  assign bus.rx_data  = w_rx_data;

  uart_rx_core #(.CPB(CPB)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .i_rx      (uart_rx),
    .o_rx_data (w_rx_data),
    .o_rx_good (w_rx_good),
    .o_rx_ferr (w_rx_ferr)
  );

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph in its default 8N1 build, CLKS_PER_BIT = 10.
module tb_uart_periph;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;
  int   n_vec   = 0;
  int   n_err   = 0;

  uart_periph_if bus();

  uart_periph #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
  endtask

  // Called right after the strobe edge; checks every cycle of the 100-cycle frame.
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    for (int c = 0; c < 100; c++) begin
      int   k;
      logic e;
      k = c / 10;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      chk("tx_bit", {7'd0, uart_tx}, {7'd0, e});
      chk("tx_busy", {7'd0, bus.uart_con[1]}, 8'd1);
      if (inject && c == 29) begin
        bus.tx_data  = 8'h3C;
        bus.tx_start = 1'b1;
      end else begin
        bus.tx_start = 1'b0;
      end
      tick();
    end
    chk("tx_idle_after", {7'd0, uart_tx}, 8'd1);
    chk("tx_busy_end", {7'd0, bus.uart_con[1]}, 8'd0);
    chk("tx_done_end", {7'd0, bus.uart_con[2]}, 8'd1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) tick();
    end
    uart_rx = stop_bit;
    repeat (10) tick();
    uart_rx = 1'b1;
  endtask

  task automatic pulse_con_read();
    bus.con_read = 1'b1;
    tick();
    bus.con_read = 1'b0;
  endtask

  task automatic pulse_rx_read();
    bus.rx_read = 1'b1;
    tick();
    bus.rx_read = 1'b0;
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    bus.rx_read  = 1'b0;
    bus.con_read = 1'b0;

    // Reset state
    tick();
    chk("rst_tx", {7'd0, uart_tx}, 8'd1);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_con", {3'd0, bus.uart_con}, 8'h00);
    reset = 1'b0;
    repeat (3) tick();

    // Single frame 0xA5
    start_tx(8'hA5);
    tx_frame(8'hA5, 1'b0);
    pulse_con_read();
    chk("done_cleared", {3'd0, bus.uart_con}, 8'h00);

    // Strobe at cycle 30 of a busy frame is dropped
    start_tx(8'hA5);
    tx_frame(8'hA5, 1'b1);
    for (int i = 0; i < 30; i++) begin
      chk("no_second_frame", {7'd0, uart_tx}, 8'd1);
      tick();
    end
    chk("busy_after_ignore", {7'd0, bus.uart_con[1]}, 8'd0);
    pulse_con_read();
    chk("con_clear2", {3'd0, bus.uart_con}, 8'h00);

    // Receive 0x5A and clear via RXD read
    rx_frame(8'h5A, 1'b1);
    chk("rx_data_5a", bus.rx_data, 8'h5A);
    chk("rx_valid_set", {3'd0, bus.uart_con}, 8'h01);
    pulse_rx_read();
    chk("rx_valid_clr", {3'd0, bus.uart_con}, 8'h00);
    chk("rx_data_kept", bus.rx_data, 8'h5A);

    // Overrun: 0x11 then 0x22 without reading
    rx_frame(8'h11, 1'b1);
    chk("rx_data_11", bus.rx_data, 8'h11);
    rx_frame(8'h22, 1'b1);
    chk("rx_data_22", bus.rx_data, 8'h22);
    chk("ovr_con", {3'd0, bus.uart_con}, 8'h09);
    pulse_con_read();
    chk("ovr_clr", {3'd0, bus.uart_con}, 8'h01);
    pulse_rx_read();
    chk("valid_clr2", {3'd0, bus.uart_con}, 8'h00);

    // Framing error: stop bit low, byte discarded
    rx_frame(8'h77, 1'b0);
    chk("ferr_con", {3'd0, bus.uart_con}, 8'h10);
    chk("ferr_data_kept", bus.rx_data, 8'h22);
    repeat (20) tick();
    chk("ferr_no_extra", {3'd0, bus.uart_con}, 8'h10);
    pulse_con_read();
    chk("ferr_clr", {3'd0, bus.uart_con}, 8'h00);

    // 3-cycle glitch: no flags, then a clean frame proves RX is idle again
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    chk("glitch_con", {3'd0, bus.uart_con}, 8'h00);
    chk("glitch_data", bus.rx_data, 8'h22);
    rx_frame(8'hC3, 1'b1);
    chk("post_glitch_data", bus.rx_data, 8'hC3);
    chk("post_glitch_con", {3'd0, bus.uart_con}, 8'h01);

    // Reset at cycle 45 of a TX frame
    start_tx(8'hA5);
    repeat (45) tick();
    chk("mid_frame_tx", {7'd0, uart_tx}, 8'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_tx", {7'd0, uart_tx}, 8'd1);
    chk("async_rst_con", {3'd0, bus.uart_con}, 8'h00);
    chk("async_rst_data", bus.rx_data, 8'h00);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("post_rst_idle", {7'd0, uart_tx}, 8'd1);
    start_tx(8'h3C);
    tx_frame(8'h3C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
